shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- EarlyOut, 0, 1 = finish once no higher ShiftAmount bits remain; 0 = fixed 5-stage latency.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  request offered.
- ReqReady  out  1  sequencer can accept a request.
- ReqData  in  32  operand.
- ReqAmount  in  5  shift amount.
- ReqMode  in  2  00 SLL, 01 SRL, 10 ROL, 11 SRA.
- RspValid  out  1  result available.
- RspReady  in  1  consumer accepts result.
- RspResult  out  32  shifted result.
- Busy  out  1  high in any state other than IDLE.
REQ-003 Clocking SHALL be one clock; reset asynchronous and active-high, ports named Clock and Reset.

Function
REQ-004 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-005 IDLE SHALL drive ReqReady=1; accept when ReqValid=1 at a rising edge.
- Latch ReqData into the work register.
- Latch ReqAmount and ReqMode.
- Stage counter k=0; go to SHIFT.
REQ-006 SHIFT SHALL process one binary stage k per edge.
- If amount[k]=1, shift the work register by 2^k per mode; otherwise hold it.
- Then k=k+1.
REQ-007 Fill rules SHALL be per mode.
- SLL: zeros into the LSBs.
- SRL: zeros into the MSBs.
- SRA: copies of current work[31] into the MSBs.
- ROL: the bits shifted out of the MSBs enter the LSBs.
REQ-008 With EarlyOut=0, SHIFT SHALL exit to DONE on the edge processing k=4.
- Request accepted at edge N: RspValid=1 from edge N+5.
REQ-009 With EarlyOut=1, SHIFT SHALL exit to DONE on the edge where amount bits [4:k+1] are all zero.
- Latency = max(1, m+1) edges, m = index of the highest set amount bit.
- Amount 0: result equals ReqData one edge after acceptance.
REQ-010 DONE SHALL hold RspValid=1 with RspResult stable until RspReady=1 at an edge, then go to IDLE.
REQ-011 ReqReady SHALL be 0 in SHIFT and DONE.
- ReqValid is ignored there; no request accepted in the DONE handshake cycle.
REQ-012 RspResult SHALL equal the work register in DONE and 0 in all other states.
REQ-013 A shift of exactly 32 is impossible (5-bit amount).
- The result for amount a SHALL equal the single-step reference shift by a, for all 32-bit data and all a in 0..31.
REQ-014 RspReady asserted outside DONE SHALL have no effect.

Reset
REQ-015 Reset=1 SHALL immediately (asynchronously) force all of the following:
- State IDLE.
- ReqReady=1, RspValid=0, Busy=0.
- RspResult=0, work register=0, k=0.
REQ-016 Reset during SHIFT or DONE SHALL discard the in-flight transaction with no response.
- The first edge after Reset deasserts SHALL be able to accept a new request.

Verification
REQ-017 SLL: 0x00000001, amount 31, EarlyOut=0 -> RspValid at edge N+5, RspResult=0x80000000.
REQ-018 SRA/SRL: 0x80000000, amount 4 -> SRA gives 0xF8000000; SRL gives 0x08000000.
REQ-019 ROL: 0x80000001, amount 1 -> 0x00000003; EarlyOut=1 -> RspValid at edge N+1.
REQ-020 Backpressure: RspReady low 3 cycles after RspValid, ReqValid held high.
- RspResult stable; ReqReady=0; no second accept.
- RspReady high -> IDLE next edge, then the new request is accepted.
REQ-021 Reset asserted mid-SHIFT (k=2) -> outputs immediately at reset values.
- Post-reset request SRL 0xFFFFFFFF, amount 8 -> 0x00FFFFFF.
REQ-022 EarlyOut=1, amount 0, data 0x12345678 -> RspResult=0x12345678 at edge N+1.

Source files
------------

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle barrel shifter. Accepts a 32-bit operand, a 5-bit
//               amount and a mode (SLL/SRL/ROL/SRA), applies one binary stage
//               (shift by 2^k) per clock, then holds the result in a
//               valid/ready response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter bit EarlyOut = 1'b0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqData,
  input  logic [4:0]  ReqAmount,
  input  logic [1:0]  ReqMode,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspResult,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_SRA = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  amount_q, amount_d;
  logic [1:0]  mode_q, mode_d;
  logic [2:0]  k_q, k_d;

  logic [4:0]  step;
  logic [31:0] shifted;
  logic        last_stage;

  // Stage datapath: work register shifted by 2^k according to the latched mode.
  always_comb begin
    step    = 5'd1 << k_q;
    shifted = work_q;
    case (mode_q)
      MODE_SLL: shifted = work_q << step;
      MODE_SRL: shifted = work_q >> step;
      // step is always a power of two >= 1, so 32-step never reaches 32.
      MODE_ROL: shifted = (work_q << step) | (work_q >> (6'd32 - {1'b0, step}));
      MODE_SRA: shifted = $signed(work_q) >>> step;
      default:  shifted = work_q;
    endcase
  end

  // Exit condition: fixed at stage 4, or as soon as no higher amount bits remain.
  always_comb begin
    if (EarlyOut) begin
      last_stage = ((amount_q >> (k_q + 3'd1)) == 5'd0);
    end else begin
      last_stage = (k_q == 3'd4);
    end
  end

  // Next-state logic and outputs; outputs depend only on state so reset clears them at once.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    amount_d  = amount_q;
    mode_d    = mode_q;
    k_d       = k_q;
    ReqReady  = 1'b0;
    RspValid  = 1'b0;
    RspResult = 32'd0;
    Busy      = 1'b1;
    case (state_q)
      IDLE: begin
        ReqReady = 1'b1;
        Busy     = 1'b0;
        if (ReqValid) begin
          work_d   = ReqData;
          amount_d = ReqAmount;
          mode_d   = ReqMode;
          k_d      = 3'd0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (amount_q[k_q]) begin
          work_d = shifted;
        end
        k_d = k_q + 3'd1;
        if (last_stage) begin
          state_d = DONE;
        end
      end
      DONE: begin
        RspValid  = 1'b1;
        RspResult = work_q;
        if (RspReady) begin
          k_d     = 3'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      work_q   <= 32'd0;
      amount_q <= 5'd0;
      mode_q   <= 2'b00;
      k_q      <= 3'd0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      amount_q <= amount_d;
      mode_q   <= mode_d;
      k_q      <= k_d;
    end
  end

endmodule
`default_nettype wire
